// File: rtl/window_median_mc_if.sv
// Sample-in / result-out bundle for window_median_mc; the filter takes the slave side.
interface window_median_mc_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CH_W       = 2
);
    logic                  enable;
    logic [CH_W-1:0]       ch_in;
    logic [DATA_WIDTH-1:0] in;
    logic [1:0]            mode;
    logic                  flush;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out;
    logic [CH_W-1:0]       out_ch;
    logic                  out_enable;
    logic                  overrun;

    modport master (
        output enable, ch_in, in, mode, flush,
        input  in_ready, out, out_ch, out_enable, overrun
    );

    modport slave (
        input  enable, ch_in, in, mode, flush,
        output in_ready, out, out_ch, out_enable, overrun
    );
endinterface

// File: rtl/window_median_mc.sv
// Multi-channel sliding-window median/min/max filter with incrementally sorted windows.
// Latency: out_enable 2 clocks after the accepting edge; in_ready low in UPD/OUT, extra samples dropped and flagged.
module window_median_mc #(
    parameter int DATA_WIDTH      = 16,
    parameter int DEPTH           = 11,
    parameter int CHANNELS        = 4,
    parameter int SIGNED          = 0,
    parameter int WARMUP_SUPPRESS = 0
) (
    input  logic              ck100m,
    input  logic              srst_n,
    window_median_mc_if.slave bus
);
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, UPD, OUT} state_t;
    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] win [CHANNELS][DEPTH];
    logic [DATA_WIDTH-1:0] srt [CHANNELS][DEPTH];
    logic [FILL_W-1:0]     fill [CHANNELS];

    logic [DATA_WIDTH-1:0] smp;
    logic [CH_W-1:0]       smp_ch;
    logic [1:0]            smp_mode;
    logic                  warm;

    logic [DATA_WIDTH-1:0] oldest;
    logic [DATA_WIDTH-1:0] rem     [DEPTH];
    logic [DATA_WIDTH-1:0] srt_nxt [DEPTH];
    logic [DATA_WIDTH-1:0] pick;
    logic [FILL_W-1:0]     fill_inc;
    logic                  accept;
    int                    r;
    int                    cnt;

    function automatic logic le(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        if (SIGNED != 0) return $signed(a) <= $signed(b);
        return a <= b;
    endfunction

    assign bus.in_ready = (state == IDLE);
    assign accept = (state == IDLE) && bus.enable && !bus.flush && (int'(bus.ch_in) < CHANNELS);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = UPD;
            UPD:     state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The retiring sample is always present in the sorted copy; drop its lowest-index twin,
    // then insert the new sample after every remaining entry that is <= it (stable for ties).
    always_comb begin
        oldest = win[smp_ch][DEPTH-1];
        r = DEPTH - 1;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (srt[smp_ch][i] == oldest) r = i;
        for (int i = 0; i < DEPTH; i++) rem[i] = '0;
        for (int i = 0; i < DEPTH - 1; i++)
            rem[i] = (i < r) ? srt[smp_ch][i] : srt[smp_ch][i+1];
        cnt = 0;
        for (int i = 0; i < DEPTH - 1; i++)
            if (le(rem[i], smp)) cnt = cnt + 1;
        srt_nxt[0] = (cnt == 0) ? smp : rem[0];
        for (int i = 1; i < DEPTH; i++) begin
            if (i < cnt)       srt_nxt[i] = rem[i];
            else if (i == cnt) srt_nxt[i] = smp;
            else               srt_nxt[i] = rem[i-1];
        end
        case (smp_mode)
            2'd0:    pick = srt_nxt[DEPTH/2];
            2'd1:    pick = srt_nxt[0];
            2'd2:    pick = srt_nxt[DEPTH-1];
            default: pick = smp;
        endcase
        fill_inc = (fill[smp_ch] == FULL) ? fill[smp_ch] : fill[smp_ch] + 1'b1;
    end

    always_ff @(posedge ck100m) begin
        if (!srst_n) begin
            state          <= IDLE;
            smp            <= '0;
            smp_ch         <= '0;
            smp_mode       <= '0;
            warm           <= 1'b0;
            bus.out        <= '0;
            bus.out_ch     <= '0;
            bus.out_enable <= 1'b0;
            bus.overrun    <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                fill[c] <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    win[c][i] <= '0;
                    srt[c][i] <= '0;
                end
            end
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (bus.flush) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        fill[c] <= '0;
                        for (int i = 0; i < DEPTH; i++) begin
                            win[c][i] <= '0;
                            srt[c][i] <= '0;
                        end
                    end
                end else if (accept) begin
                    smp      <= bus.in;
                    smp_ch   <= bus.ch_in;
                    smp_mode <= bus.mode;
                end
            end
            if (state == UPD) begin
                for (int i = DEPTH - 1; i >= 1; i--)
                    win[smp_ch][i] <= win[smp_ch][i-1];
                win[smp_ch][0] <= smp;
                for (int i = 0; i < DEPTH; i++)
                    srt[smp_ch][i] <= srt_nxt[i];
                fill[smp_ch] <= fill_inc;
                warm         <= (fill_inc == FULL);
                bus.out      <= pick;
                bus.out_ch   <= smp_ch;
            end
            bus.out_enable <= (state == OUT) && ((WARMUP_SUPPRESS == 0) || warm);
            if (bus.enable && state != IDLE) bus.overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_window_median_mc.sv
// Drives three filter instances (multi-channel unsigned, warm-up suppressed, signed) against a sort-based window model.
module tb_window_median_mc;
    logic ck100m = 1'b0;
    always #5 ck100m = ~ck100m;

    logic        srst_n;
    logic        s_en, s_flush;
    logic [1:0]  s_ch, s_mode;
    logic [15:0] s_din;
    int          sel;

    window_median_mc_if #(.DATA_WIDTH(16), .CH_W(2)) if0 ();
    window_median_mc_if #(.DATA_WIDTH(16), .CH_W(1)) if1 ();
    window_median_mc_if #(.DATA_WIDTH(16), .CH_W(1)) if2 ();

    assign if0.enable = s_en && (sel == 0);
    assign if1.enable = s_en && (sel == 1);
    assign if2.enable = s_en && (sel == 2);
    assign if0.flush  = s_flush && (sel == 0);
    assign if1.flush  = s_flush && (sel == 1);
    assign if2.flush  = s_flush && (sel == 2);
    assign if0.ch_in  = s_ch;
    assign if1.ch_in  = s_ch[0];
    assign if2.ch_in  = s_ch[0];
    assign if0.in     = s_din;
    assign if1.in     = s_din;
    assign if2.in     = s_din;
    assign if0.mode   = s_mode;
    assign if1.mode   = s_mode;
    assign if2.mode   = s_mode;

    window_median_mc #(.DATA_WIDTH(16), .DEPTH(11), .CHANNELS(3), .SIGNED(0), .WARMUP_SUPPRESS(0))
        dut0 (.ck100m(ck100m), .srst_n(srst_n), .bus(if0));
    window_median_mc #(.DATA_WIDTH(16), .DEPTH(11), .CHANNELS(1), .SIGNED(0), .WARMUP_SUPPRESS(1))
        dut1 (.ck100m(ck100m), .srst_n(srst_n), .bus(if1));
    window_median_mc #(.DATA_WIDTH(16), .DEPTH(11), .CHANNELS(1), .SIGNED(1), .WARMUP_SUPPRESS(0))
        dut2 (.ck100m(ck100m), .srst_n(srst_n), .bus(if2));

    logic        oe  [3];
    logic [15:0] od  [3];
    logic [1:0]  och [3];
    logic        ovr [3];
    logic        rdy [3];
    assign oe[0]  = if0.out_enable;  assign oe[1]  = if1.out_enable;  assign oe[2]  = if2.out_enable;
    assign od[0]  = if0.out;         assign od[1]  = if1.out;         assign od[2]  = if2.out;
    assign och[0] = if0.out_ch;      assign och[1] = {1'b0, if1.out_ch}; assign och[2] = {1'b0, if2.out_ch};
    assign ovr[0] = if0.overrun;     assign ovr[1] = if1.overrun;     assign ovr[2] = if2.overrun;
    assign rdy[0] = if0.in_ready;    assign rdy[1] = if1.in_ready;    assign rdy[2] = if2.in_ready;

    typedef struct {
        int          k;
        int          ch;
        logic [15:0] dat;
        int          edge_n;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge ck100m) cyc <= cyc + 1;

    logic [15:0] mw [3][3][11];
    int          mf [3][3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic gt(input logic [15:0] a, input logic [15:0] b, input bit sg);
        if (sg) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    task automatic model_clear(input int k);
        for (int c = 0; c < 3; c++) begin
            mf[k][c] = 0;
            for (int i = 0; i < 11; i++) mw[k][c][i] = 16'd0;
        end
    endtask

    task automatic model_push(input int k, input int ch, input logic [15:0] v,
                              input logic [1:0] md, input int edge_n);
        logic [15:0] t [11];
        logic [15:0] x;
        exp_t        e;
        for (int i = 10; i >= 1; i--) mw[k][ch][i] = mw[k][ch][i-1];
        mw[k][ch][0] = v;
        if (mf[k][ch] < 11) mf[k][ch]++;
        for (int i = 0; i < 11; i++) t[i] = mw[k][ch][i];
        for (int p = 0; p < 10; p++)
            for (int i = 0; i < 10 - p; i++)
                if (gt(t[i], t[i+1], k == 2)) begin
                    x = t[i]; t[i] = t[i+1]; t[i+1] = x;
                end
        case (md)
            2'd0:    e.dat = t[5];
            2'd1:    e.dat = t[0];
            2'd2:    e.dat = t[10];
            default: e.dat = v;
        endcase
        e.k = k; e.ch = ch; e.edge_n = edge_n;
        if (!(k == 1 && mf[k][ch] < 11)) sb.push_back(e);
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (rdy[k] !== 1'b1 && n < 20) begin
            @(negedge ck100m);
            n++;
        end
        if (n >= 20) chk("idle_timeout", 0, 1);
    endtask

    task automatic send(input int k, input int ch, input logic [15:0] v, input logic [1:0] md);
        int en;
        int nch;
        nch = (k == 0) ? 3 : 1;
        wait_idle(k);
        sel = k; s_ch = 2'(ch); s_din = v; s_mode = md; s_en = 1'b1;
        en = cyc + 1;
        @(posedge ck100m);
        @(negedge ck100m);
        s_en = 1'b0;
        if (ch < nch) model_push(k, ch, v, md, en);
    endtask

    task automatic do_flush(input int k, input bit with_en, input logic [15:0] v);
        wait_idle(k);
        sel = k; s_ch = 2'd0; s_din = v; s_mode = 2'd3; s_en = with_en; s_flush = 1'b1;
        @(posedge ck100m);
        @(negedge ck100m);
        s_flush = 1'b0; s_en = 1'b0;
        model_clear(k);
    endtask

    task automatic drain();
        repeat (6) @(negedge ck100m);
        chk("drain_empty", sb.size(), 0);
    endtask

    // Every result pulse must match the oldest outstanding expectation, two edges after acceptance.
    always @(negedge ck100m) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (oe[k] === 1'b1) begin
                if (sb.size() == 0) begin
                    chk($sformatf("spurious_oe_dut%0d", k), 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("oe_dut", k, e.k);
                    chk("oe_ch", och[k], e.ch);
                    chk("oe_dat", od[k], e.dat);
                    chk("oe_latency", cyc - e.edge_n, 2);
                end
            end
        end
    end

    initial begin
        int en;
        srst_n = 1'b0; s_en = 1'b0; s_flush = 1'b0; s_ch = '0; s_mode = '0; s_din = '0; sel = 0;
        for (int k = 0; k < 3; k++) model_clear(k);
        repeat (3) @(negedge ck100m);
        srst_n = 1'b1;
        @(negedge ck100m);
        for (int k = 0; k < 3; k++) begin
            chk("rst_out", od[k], 0);
            chk("rst_out_ch", och[k], 0);
            chk("rst_out_enable", oe[k], 0);
            chk("rst_overrun", ovr[k], 0);
            chk("rst_in_ready", rdy[k], 1);
        end

        // ramp on ch0 from the reset (all-zero) window
        for (int v = 1; v <= 11; v++) send(0, 0, 16'(v), 2'd0);
        send(0, 0, 16'd100, 2'd0);
        drain();
        chk("ramp_after_100", od[0], 7);

        // duplicate removal and mode selection
        do_flush(0, 1'b0, 16'd0);
        for (int i = 0; i < 11; i++) send(0, 0, 16'd5, 2'd0);
        send(0, 0, 16'd3, 2'd0); drain(); chk("dup_median", od[0], 5);
        send(0, 0, 16'd3, 2'd1); drain(); chk("dup_min", od[0], 3);
        send(0, 0, 16'd3, 2'd2); drain(); chk("dup_max", od[0], 5);
        send(0, 0, 16'd3, 2'd3); drain(); chk("dup_bypass", od[0], 3);

        // interleaved channels
        do_flush(0, 1'b0, 16'd0);
        for (int i = 1; i <= 8; i++) begin
            send(0, 0, 16'(10 * i), 2'd0);
            send(0, 1, 16'd1000, 2'd0);
        end
        drain();
        chk("ch1_median", od[0], 1000);
        chk("ch1_tag", och[0], 1);
        send(0, 3, 16'd55, 2'd3);
        drain();
        chk("bad_ch_ready", rdy[0], 1);
        chk("bad_ch_no_overrun", ovr[0], 0);

        // overrun: second consecutive enable is dropped
        do_flush(0, 1'b0, 16'd0);
        wait_idle(0);
        sel = 0; s_ch = 2'd0; s_mode = 2'd3; s_din = 16'd7; s_en = 1'b1;
        en = cyc + 1;
        @(posedge ck100m);
        @(negedge ck100m);
        s_din = 16'd9;
        @(posedge ck100m);
        @(negedge ck100m);
        s_en = 1'b0;
        model_push(0, 0, 16'd7, 2'd3, en);
        drain();
        chk("overrun_set", ovr[0], 1);
        send(0, 0, 16'd8, 2'd3);
        drain();
        chk("overrun_sticky", ovr[0], 1);

        // warm-up suppression
        for (int v = 1; v <= 10; v++) send(1, 0, 16'(v), 2'd0);
        drain();
        send(1, 0, 16'd11, 2'd0);
        drain();
        chk("warmup_first", od[1], 6);
        do_flush(1, 1'b0, 16'd0);
        send(1, 0, 16'd42, 2'd0);
        drain();
        do_flush(1, 1'b1, 16'd77);
        send(1, 1, 16'd5, 2'd0);
        drain();
        chk("flush_en_no_overrun", ovr[1], 0);
        for (int v = 1; v <= 11; v++) send(1, 0, 16'(v), 2'd0);
        drain();
        chk("warmup_restart", od[1], 6);

        // signed vs unsigned minimum
        send(2, 0, 16'd2, 2'd1);
        send(2, 0, 16'hFFFD, 2'd1);
        drain();
        chk("signed_min", od[2], 16'hFFFD);
        do_flush(0, 1'b0, 16'd0);
        send(0, 0, 16'd2, 2'd1);
        send(0, 0, 16'hFFFD, 2'd1);
        drain();
        chk("unsigned_min", od[0], 0);

        // reset while UPD abandons the transaction
        wait_idle(2);
        sel = 2; s_ch = 2'd0; s_mode = 2'd3; s_din = 16'd123; s_en = 1'b1;
        @(posedge ck100m);
        @(negedge ck100m);
        s_en = 1'b0;
        srst_n = 1'b0;
        @(posedge ck100m);
        @(negedge ck100m);
        srst_n = 1'b1;
        for (int k = 0; k < 3; k++) model_clear(k);
        drain();
        for (int k = 0; k < 3; k++) begin
            chk("post_rst_out", od[k], 0);
            chk("post_rst_out_ch", och[k], 0);
            chk("post_rst_overrun", ovr[k], 0);
            chk("post_rst_ready", rdy[k], 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
